// File: rtl/fast_square_sweep_ctrl.sv
// fast_square_sweep_ctrl: sequences a stepped-frequency sweep and forwards recorded datapath words.
// Ports:
//   clock, reset_n              : rising-edge clock, asynchronous active-low reset
//   start, abort                : single-cycle sweep request / cancel
//   num_steps, dwell            : steps per sweep and words per step, latched on accepted start
//   dp_reset, freq_step, record : datapath reset, one-cycle step pulse, recording window
//   dp_strobe, i_word, q_word   : datapath word strobe and data
//   out_valid/out_ready, out_i, out_q, out_step : single-entry forwarded word with its step index
//   busy, done, overflow        : sweep active, one-cycle completion pulse, sticky dropped-word flag
module fast_square_sweep_ctrl #(
    parameter int WARMUP_STROBES = 202,
    parameter int SETTLE_STROBES = 2,
    parameter int RST_CYCLES     = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  num_steps,
    input  logic [11:0] dwell,
    output logic        dp_reset,
    output logic        freq_step,
    output logic        record,
    input  logic        dp_strobe,
    input  logic [15:0] i_word,
    input  logic [15:0] q_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_i,
    output logic [15:0] out_q,
    output logic [7:0]  out_step,
    output logic        busy,
    output logic        done,
    output logic        overflow
);
    typedef enum logic [2:0] {IDLE, DP_RST, WARMUP, RECORD, STEP, SETTLE} state_t;

    localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
    localparam logic [15:0] WARMUP_LAST = 16'(WARMUP_STROBES - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_STROBES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  step_q, step_d, nsteps_q, nsteps_d;
    logic [11:0] dwell_q, dwell_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] out_i_q, out_i_d, out_q_q, out_q_d;
    logic [7:0]  out_step_q, out_step_d;
    logic        done_q, done_d, overflow_q, overflow_d;
    logic        cap, go, kill;
    logic [11:0] dwell_m1;

    assign dp_reset  = state_q == DP_RST;
    assign freq_step = state_q == STEP;
    assign record    = state_q == RECORD;
    assign busy      = state_q != IDLE;
    assign out_valid = out_valid_q;
    assign out_i     = out_i_q;
    assign out_q     = out_q_q;
    assign out_step  = out_step_q;
    assign done      = done_q;
    assign overflow  = overflow_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        step_d      = step_q;
        nsteps_d    = nsteps_q;
        dwell_d     = dwell_q;
        out_valid_d = out_valid_q;
        out_i_d     = out_i_q;
        out_q_d     = out_q_q;
        out_step_d  = out_step_q;
        done_d      = 1'b0;
        overflow_d  = overflow_q;
        kill        = abort && state_q != IDLE;
        go          = start && !abort && state_q == IDLE;
        cap         = dp_strobe && state_q == RECORD;
        // a dwell of zero records one word per step
        dwell_m1    = (dwell_q == 12'd0) ? 12'd0 : dwell_q - 12'd1;
        // single-entry output register: a capture loads unless a word is still waiting
        if (cap && (!out_valid_q || out_ready)) begin
            out_valid_d = 1'b1;
            out_i_d     = i_word;
            out_q_d     = q_word;
            out_step_d  = step_q;
        end else begin
            out_valid_d = out_valid_q && !out_ready;
            overflow_d  = overflow_q || cap;
        end
        case (state_q)
            IDLE: if (go) begin
                nsteps_d   = num_steps;
                dwell_d    = dwell;
                step_d     = 8'd0;
                cnt_d      = 16'd0;
                overflow_d = 1'b0;
                done_d     = num_steps == 8'd0;
                state_d    = (num_steps == 8'd0) ? IDLE : DP_RST;
            end
            DP_RST: begin
                cnt_d = (cnt_q == RST_LAST) ? 16'd0 : cnt_q + 16'd1;
                if (cnt_q == RST_LAST) state_d = (WARMUP_STROBES == 0) ? RECORD : WARMUP;
            end
            WARMUP: if (dp_strobe) begin
                cnt_d = (cnt_q == WARMUP_LAST) ? 16'd0 : cnt_q + 16'd1;
                if (cnt_q == WARMUP_LAST) state_d = RECORD;
            end
            RECORD: if (cap) begin
                cnt_d = (cnt_q == {4'd0, dwell_m1}) ? 16'd0 : cnt_q + 16'd1;
                if (cnt_q == {4'd0, dwell_m1}) begin
                    state_d = (step_q < nsteps_q - 8'd1) ? STEP : IDLE;
                    done_d  = !(step_q < nsteps_q - 8'd1);
                end
            end
            STEP: begin
                step_d  = step_q + 8'd1;
                cnt_d   = 16'd0;
                state_d = (SETTLE_STROBES == 0) ? RECORD : SETTLE;
            end
            SETTLE: if (dp_strobe) begin
                cnt_d = (cnt_q == SETTLE_LAST) ? 16'd0 : cnt_q + 16'd1;
                if (cnt_q == SETTLE_LAST) state_d = RECORD;
            end
            default: state_d = IDLE;
        endcase
        // abort beats everything: drop the sweep and the pending word, no done
        if (kill) begin
            state_d     = IDLE;
            cnt_d       = 16'd0;
            step_d      = 8'd0;
            out_valid_d = 1'b0;
            overflow_d  = overflow_q;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            step_q      <= 8'd0;
            nsteps_q    <= 8'd0;
            dwell_q     <= 12'd0;
            out_valid_q <= 1'b0;
            out_i_q     <= 16'd0;
            out_q_q     <= 16'd0;
            out_step_q  <= 8'd0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            nsteps_q    <= nsteps_d;
            dwell_q     <= dwell_d;
            out_valid_q <= out_valid_d;
            out_i_q     <= out_i_d;
            out_q_q     <= out_q_d;
            out_step_q  <= out_step_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
        end
    end
endmodule

// File: tb/tb_fast_square_sweep_ctrl.sv
// tb_fast_square_sweep_ctrl: directed sweeps with random data, gaps and backpressure against a word-level model.
module tb_fast_square_sweep_ctrl;
    localparam int WU = 202;

    logic        clock = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic        dp_strobe = 1'b0, out_ready = 1'b1;
    logic [7:0]  num_steps = 8'd0;
    logic [11:0] dwell = 12'd0;
    logic [15:0] i_word = 16'd0, q_word = 16'd0;
    logic        dp_reset, freq_step, record, out_valid, busy, done, overflow;
    logic [15:0] out_i, out_q;
    logic [7:0]  out_step;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int rmode = 0;
    // expected output-register contents, overflow flag and sweep activity
    logic        m_v = 1'b0, m_ovf = 1'b0, m_busy = 1'b0, cap = 1'b0;
    logic [15:0] m_i = 16'd0, m_q = 16'd0;
    logic [7:0]  m_s = 8'd0, cap_step = 8'd0;

    fast_square_sweep_ctrl dut (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
        .num_steps(num_steps), .dwell(dwell), .dp_reset(dp_reset), .freq_step(freq_step),
        .record(record), .dp_strobe(dp_strobe), .i_word(i_word), .q_word(q_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_i(out_i), .out_q(out_q),
        .out_step(out_step), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock: update the model from the inputs presented at this edge, then compare
    task automatic cyc();
        if (rmode == 2) out_ready = 1'($urandom_range(0, 1));
        if (reset_n) begin
            if (abort && m_busy) begin
                m_v = 1'b0;
                m_busy = 1'b0;
            end else begin
                if (start && !abort && !m_busy) begin
                    m_ovf = 1'b0;
                    m_busy = num_steps != 8'd0;
                end
                if (cap) begin
                    if (!m_v || out_ready) begin
                        m_v = 1'b1; m_i = i_word; m_q = q_word; m_s = cap_step;
                    end else m_ovf = 1'b1;
                end else if (m_v && out_ready) m_v = 1'b0;
            end
        end
        @(posedge clock); #1;
        chk("out_valid", 32'(out_valid), 32'(m_v));
        chk("out_i", 32'(out_i), 32'(m_i));
        chk("out_q", 32'(out_q), 32'(m_q));
        chk("out_step", 32'(out_step), 32'(m_s));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("busy", 32'(busy), 32'(m_busy));
    endtask

    task automatic idle(input int g);
        for (int k = 0; k < g; k++) cyc();
    endtask

    task automatic gap();
        idle($urandom_range(1, 3));
    endtask

    task automatic strobe(input logic c, input logic [7:0] s);
        dp_strobe = 1'b1; i_word = 16'($urandom); q_word = 16'($urandom);
        cap = c; cap_step = s;
        cyc();
        dp_strobe = 1'b0; cap = 1'b0;
    endtask

    // rm: 0 always ready, 1 not ready during step 0, 2 random ready
    task automatic sweep(input int n, input int d, input int rm, input int abort_step,
                         input int reset_step, input bit poke);
        int de;
        de = (d == 0) ? 1 : d;
        rmode = rm;
        out_ready = (rm == 1) ? 1'b0 : 1'b1;
        num_steps = 8'(n); dwell = 12'(d); start = 1'b1;
        cyc();
        start = 1'b0;
        chk("dp_reset_rise", 32'(dp_reset), 1);
        for (int k = 0; k < 3; k++) begin
            dp_strobe = 1'($urandom_range(0, 1));
            cyc();
            chk("dp_reset_hold", 32'(dp_reset), 1);
        end
        dp_strobe = 1'b0;
        cyc();
        chk("dp_reset_fall", 32'(dp_reset), 0);
        chk("record_warmup", 32'(record), 0);
        for (int k = 0; k < WU; k++) begin
            if (poke && k == 5) begin
                num_steps = 8'd9; dwell = 12'd7; start = 1'b1;
                cyc();
                start = 1'b0; num_steps = 8'(n); dwell = 12'(d);
                chk("busy_start_ignored", 32'(dp_reset), 0);
            end
            strobe(1'b0, 8'd0);
            chk("record_warm", 32'(record), 32'(k == WU - 1));
            gap();
        end
        for (int s = 0; s < n; s++) begin
            if (s == 1 && rm == 1) out_ready = 1'b1;
            if (s > 0) begin
                strobe(1'b0, 8'd0);
                chk("record_settle", 32'(record), 0);
                if (s == abort_step) begin
                    gap();
                    abort = 1'b1;
                    cyc();
                    abort = 1'b0;
                    chk("abort_record", 32'(record), 0);
                    chk("abort_done", 32'(done), 0);
                    idle(2);
                    chk("abort_no_done", 32'(done), 0);
                    return;
                end
                gap();
                strobe(1'b0, 8'd0);
                chk("record_resume", 32'(record), 1);
                gap();
            end
            for (int j = 0; j < de; j++) begin
                if (j == de - 1 && s == n - 1) m_busy = 1'b0;
                strobe(1'b1, 8'(s));
                if (s == reset_step) begin
                    reset_n = 1'b0;
                    #1;
                    chk("rst_out_valid", 32'(out_valid), 0);
                    chk("rst_out_i", 32'(out_i), 0);
                    chk("rst_out_q", 32'(out_q), 0);
                    chk("rst_out_step", 32'(out_step), 0);
                    chk("rst_overflow", 32'(overflow), 0);
                    chk("rst_busy", 32'(busy), 0);
                    chk("rst_record", 32'(record), 0);
                    chk("rst_done", 32'(done), 0);
                    m_v = 1'b0; m_i = 16'd0; m_q = 16'd0; m_s = 8'd0; m_ovf = 1'b0; m_busy = 1'b0;
                    cyc();
                    reset_n = 1'b1;
                    idle(2);
                    chk("post_rst_done", 32'(done), 0);
                    chk("post_rst_dp_reset", 32'(dp_reset), 0);
                    return;
                end
                if (j == de - 1) begin
                    if (s < n - 1) begin
                        chk("fstep_pulse", 32'(freq_step), 1);
                        chk("record_step", 32'(record), 0);
                        cyc();
                        chk("fstep_end", 32'(freq_step), 0);
                    end else begin
                        chk("done_pulse", 32'(done), 1);
                        cyc();
                        chk("done_end", 32'(done), 0);
                    end
                end else begin
                    chk("record_rec", 32'(record), 1);
                    gap();
                end
            end
        end
        rmode = 0;
        out_ready = 1'b1;
        idle(2);
    endtask

    initial begin
        idle(2);
        chk("reset_dp_reset", 32'(dp_reset), 0);
        chk("reset_freq_step", 32'(freq_step), 0);
        chk("reset_record", 32'(record), 0);
        chk("reset_done", 32'(done), 0);
        reset_n = 1'b1;
        idle(2);
        num_steps = 8'd2; start = 1'b1; abort = 1'b1;
        cyc();
        start = 1'b0; abort = 1'b0;
        chk("abort_start_dp_reset", 32'(dp_reset), 0);
        chk("abort_start_done", 32'(done), 0);
        num_steps = 8'd0; dwell = 12'd5; start = 1'b1;
        cyc();
        start = 1'b0;
        chk("zero_done", 32'(done), 1);
        chk("zero_dp_reset", 32'(dp_reset), 0);
        cyc();
        chk("zero_done_end", 32'(done), 0);
        chk("zero_dp_reset_end", 32'(dp_reset), 0);
        sweep(3, 4, 0, -1, -1, 1'b0);
        sweep(2, 3, 1, -1, -1, 1'b1);
        sweep(3, 2, 1, 1, -1, 1'b0);
        sweep(2, 0, 2, -1, -1, 1'b0);
        sweep(3, 3, 1, -1, 1, 1'b0);
        sweep(4, 2, 2, -1, -1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            strobe(1'b0, 8'd0);
            chk("idle_record", 32'(record), 0);
        end
        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
